// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: keyboard codes, decoded key and repeat-state types.
package tetris_pkg;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [2:0] {NONE, LEFT, RIGHT, DOWN, ROT} key_t;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  function automatic key_t decode_key(input logic [7:0] code);
    case (code)
      KEY_A:   return LEFT;
      KEY_D:   return RIGHT;
      KEY_S:   return DOWN;
      KEY_W:   return ROT;
      default: return NONE;
    endcase
  endfunction

  // Pulse vector ordering is {rotate, soft_drop, move_right, move_left}
  function automatic logic [3:0] key_onehot(input key_t k);
    case (k)
      LEFT:    return 4'b0001;
      RIGHT:   return 4'b0010;
      DOWN:    return 4'b0100;
      ROT:     return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings an asynchronous frame strobe into the Clk domain as a one-cycle tick
// on each rising edge. Shared with the piece-motion and gravity blocks.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic async_in,
  output logic tick
);

  logic sync_1, sync_2, sync_2_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_d <= 1'b0;
      tick     <= 1'b0;
    end else begin
      sync_1   <= async_in;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
      tick     <= sync_2 & ~sync_2_d;
    end
  end

endmodule

// File: rtl/key_repeat_ctrl.sv
// Key auto-repeat (DAS/ARR, counted in frames) producing one-Clk move pulses.
// Optional macro KEYREP_SOFTDROP_FAST_EN: held S pulses soft_drop on every frame.
//
// state  | meaning
// IDLE   | no recognised key held
// DELAY  | press pulse issued, waiting DAS frames (ROT parks here for good)
// REPEAT | auto-repeating every ARR frames
module key_repeat_ctrl
  import tetris_pkg::*;
#(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic       move_left,
  output logic       move_right,
  output logic       soft_drop,
  output logic       rotate,
  output logic       key_active
);

  localparam logic [5:0] DAS_CNT = 6'(DAS_FRAMES);
  localparam logic [5:0] ARR_CNT = 6'(ARR_FRAMES);

  logic       tick;
  key_t       key;
  key_t       prev_key;
  rep_state_t state;
  logic [5:0] frame_cnt;

  frame_tick_sync u_frame_tick_sync (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .async_in (frame_clk),
    .tick     (tick)
  );

  assign key = decode_key(keycode);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      prev_key   <= NONE;
      frame_cnt  <= 6'd0;
      key_active <= 1'b0;
      {rotate, soft_drop, move_right, move_left} <= 4'b0000;
    end else begin
      {rotate, soft_drop, move_right, move_left} <= 4'b0000;
      if (tick) begin
        prev_key   <= key;
        key_active <= (key != NONE);
        if (key == NONE) begin
          state     <= IDLE;
          frame_cnt <= 6'd0;
        end else if (state == IDLE || key != prev_key) begin
          {rotate, soft_drop, move_right, move_left} <= key_onehot(key);
          state     <= DELAY;
          frame_cnt <= 6'd1;
`ifdef KEYREP_SOFTDROP_FAST_EN
          if (key == DOWN) state <= REPEAT;
`endif
        end else if (key == ROT) begin
          frame_cnt <= sat_inc(frame_cnt);
`ifdef KEYREP_SOFTDROP_FAST_EN
        end else if (key == DOWN) begin
          soft_drop <= 1'b1;
          state     <= REPEAT;
          frame_cnt <= 6'd1;
`endif
        end else if ((state == DELAY && frame_cnt == DAS_CNT) ||
                     (state == REPEAT && frame_cnt == ARR_CNT)) begin
          {rotate, soft_drop, move_right, move_left} <= key_onehot(key);
          state     <= REPEAT;
          frame_cnt <= 6'd1;
        end else begin
          frame_cnt <= sat_inc(frame_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Scoreboard bench for key_repeat_ctrl: expected pulses are queued per frame and
// matched against every observed pulse, with width and exclusivity checks.
`timescale 1ns/1ps
module tb_key_repeat_ctrl;

  localparam logic [7:0] KC_A = 8'h04, KC_D = 8'h07, KC_S = 8'h16, KC_W = 8'h1A;
  localparam int C_LEFT = 1, C_RIGHT = 2, C_DOWN = 3, C_ROT = 4;

  typedef struct {
    int frame;
    int code;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       move_left, move_right, soft_drop, rotate, key_active;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   frame_idx = 0;
  int   mon_code;
  logic [3:0] mon_p;
  logic [3:0] prev_pulses = 4'b0000;

  always #10 Clk = ~Clk;

  key_repeat_ctrl #(.DAS_FRAMES(10), .ARR_FRAMES(2)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .move_left  (move_left),
    .move_right (move_right),
    .soft_drop  (soft_drop),
    .rotate     (rotate),
    .key_active (key_active)
  );

  always @(negedge Clk) begin
    mon_p = {rotate, soft_drop, move_right, move_left};
    if (mon_p != 4'b0000) begin
      mon_code = (mon_p == 4'b0001) ? C_LEFT : (mon_p == 4'b0010) ? C_RIGHT :
                 (mon_p == 4'b0100) ? C_DOWN : (mon_p == 4'b1000) ? C_ROT : 0;
      vectors++;
      if ($countones(mon_p) != 1) begin
        miscompares++;
        $display("FAIL onehot: pulses=%b at frame %0d, required exactly one", mon_p, frame_idx);
      end
      vectors++;
      if ((mon_p & prev_pulses) != 4'b0000) begin
        miscompares++;
        $display("FAIL width: pulses=%b high two cycles at frame %0d", mon_p, frame_idx);
      end
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL extra_pulse: code %0d at frame %0d, none expected", mon_code, frame_idx);
      end else if ((mon_p & prev_pulses) == 4'b0000) begin
        mon_e = sb.pop_front();
        if (mon_e.code != mon_code || mon_e.frame != frame_idx) begin
          miscompares++;
          $display("FAIL pulse: got code %0d frame %0d, required code %0d frame %0d",
                   mon_code, frame_idx, mon_e.code, mon_e.frame);
        end
      end
    end
    prev_pulses = mon_p;
  end

  // One frame: drive keycode, raise frame_clk at a jittered time, lower it again.
  task automatic frame(input logic [7:0] kc, input int exp_code);
    keycode = kc;
    #($urandom_range(150, 350));
    frame_idx++;
    if (exp_code != 0) sb.push_back('{frame: frame_idx, code: exp_code});
    frame_clk = 1'b1;
    #($urandom_range(200, 400));
    frame_clk = 1'b0;
  endtask

  task automatic test_reset();
    keycode = KC_A;
    Reset_n = 1'b0;
    frame(KC_A, 0);
    frame(KC_A, 0);
    vectors++;
    if ({rotate, soft_drop, move_right, move_left, key_active} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required 00000",
               {rotate, soft_drop, move_right, move_left, key_active});
    end
    #37 Reset_n = 1'b1;
    #50;
    frame(KC_A, C_LEFT);
    vectors++;
    if (key_active !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_tick_active: got %b, required 1", key_active);
    end
    frame(KC_A, 0);
    frame(KC_A, 0);
    #7 Reset_n = 1'b0;
    #1;
    vectors++;
    if ({rotate, soft_drop, move_right, move_left, key_active} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_mid_hold: got %b, required 00000",
               {rotate, soft_drop, move_right, move_left, key_active});
    end
    frame(KC_A, 0);
    #23 Reset_n = 1'b1;
    #50;
    frame(KC_A, C_LEFT);
    frame(8'h00, 0);
    #100;
    vectors++;
    if (sb.size() != 0 || key_active !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_reset: %0d pulses missing, key_active %b required 0", sb.size(), key_active);
      sb.delete();
    end
  endtask

  task automatic test_tap();
    frame(KC_A, C_LEFT);
    frame(8'h00, 0);
    #100;
    vectors++;
    if (sb.size() != 0 || key_active !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_tap: %0d pulses missing, key_active %b required 0", sb.size(), key_active);
      sb.delete();
    end
  endtask

  task automatic test_hold_right();
    for (int i = 0; i < 20; i++) begin
      frame(KC_D, (i == 0 || (i >= 10 && i % 2 == 0)) ? C_RIGHT : 0);
      if (i == 5) begin
        vectors++;
        if (key_active !== 1'b1) begin
          miscompares++;
          $display("FAIL hold_active: got %b, required 1", key_active);
        end
      end
    end
    frame(8'h00, 0);
    #100;
    vectors++;
    if (sb.size() != 0 || key_active !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_hold_right: %0d pulses missing, key_active %b required 0", sb.size(), key_active);
      sb.delete();
    end
  endtask

  task automatic test_rotate_no_repeat();
    for (int i = 0; i < 30; i++) frame(KC_W, (i == 0) ? C_ROT : 0);
    vectors++;
    if (key_active !== 1'b1) begin
      miscompares++;
      $display("FAIL rot_active: got %b, required 1", key_active);
    end
    frame(8'h00, 0);
    #100;
    vectors++;
    if (sb.size() != 0 || key_active !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_rotate: %0d pulses missing, key_active %b required 0", sb.size(), key_active);
      sb.delete();
    end
  endtask

  task automatic test_switch();
    for (int i = 0; i < 5; i++) frame(KC_A, (i == 0) ? C_LEFT : 0);
    for (int j = 0; j < 12; j++) frame(KC_D, (j == 0 || j == 10) ? C_RIGHT : 0);
    frame(8'h00, 0);
    #100;
    vectors++;
    if (sb.size() != 0 || key_active !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_switch: %0d pulses missing, key_active %b required 0", sb.size(), key_active);
      sb.delete();
    end
  endtask

  task automatic test_unknown();
    for (int i = 0; i < 5; i++) frame(8'h2C, 0);
    vectors++;
    if (key_active !== 1'b0) begin
      miscompares++;
      $display("FAIL unknown_active: got %b, required 0", key_active);
    end
    frame(8'h00, 0);
    #100;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_unknown: %0d pulses missing", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_soft_drop();
    for (int i = 0; i < 5; i++) begin
`ifdef KEYREP_SOFTDROP_FAST_EN
      frame(KC_S, C_DOWN);
`else
      frame(KC_S, (i == 0) ? C_DOWN : 0);
`endif
    end
    frame(8'h00, 0);
    #100;
    vectors++;
    if (sb.size() != 0 || key_active !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_soft_drop: %0d pulses missing, key_active %b required 0", sb.size(), key_active);
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    frame(KC_A, C_LEFT);
    frame(KC_D, C_RIGHT);
    frame(KC_A, C_LEFT);
    frame(KC_W, C_ROT);
    frame(KC_S, C_DOWN);
    frame(KC_D, C_RIGHT);
    frame(8'h2C, 0);
    frame(KC_D, C_RIGHT);
    frame(8'h00, 0);
    #100;
    vectors++;
    if (sb.size() != 0 || key_active !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_back_to_back: %0d pulses missing, key_active %b required 0", sb.size(), key_active);
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold_right();
    test_rotate_no_repeat();
    test_switch();
    test_unknown();
    test_soft_drop();
    test_back_to_back();
    #200;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
